// File: rtl/uc1611_rx_if.sv
// LCD host bus plus frame-buffer write port of the UC1611 receiver.
//   lcd_cs     chip select, active-high
//   lcd_write  write strobe, active-low
//   lcd_cd     0 = command byte, 1 = display data byte
//   lcd_data   bus byte
//   fb_we      one-cycle frame-buffer write pulse
//   fb_page    write page address
//   fb_col     write column address
//   fb_data    write data (two 4-bit gray pixels)
// master = host side (drives the LCD bus), slave = receiver side.
interface uc1611_rx_if;
    logic       lcd_cs;
    logic       lcd_write;
    logic       lcd_cd;
    logic [7:0] lcd_data;
    logic       fb_we;
    logic [6:0] fb_page;
    logic [7:0] fb_col;
    logic [7:0] fb_data;

    modport master (
        output lcd_cs, lcd_write, lcd_cd, lcd_data,
        input  fb_we, fb_page, fb_col, fb_data
    );

    modport slave (
        input  lcd_cs, lcd_write, lcd_cd, lcd_data,
        output fb_we, fb_page, fb_col, fb_data
    );
endinterface

// File: rtl/uc1611_rx.sv
// UC1611 command/data receiver. Decodes host command bytes into display
// control registers and turns display data bytes into frame-buffer writes
// with automatic address advance.
// Ports:
//   clk          single clock, posedge
//   reset        synchronous, active-low
//   bus          LCD bus in, frame-buffer write port out (slave modport)
//   scroll_line  SL[7:0]
//   map_ctl      {MY,MX,MSF}
//   addr_ctl     AC[2:0]
//   disp_en      DC[4:2]
//   gray_ctl     gray-scale mode
//   line_rate    line-rate select
//   bias         BR[1:0]
//   panel_ld     PC[1:0]
//   gain_pm      {GN,PM}
//   partial      partial-display bits
//   busy         high while accepted bytes are being ignored
//
// state | meaning
// CMD   | decoding commands / accepting data
// ARG   | next accepted byte is the 0x81 argument
// RSTW  | post System Reset wait, bus ignored
module uc1611_rx #(
    parameter int NUM_COLS  = 160,
    parameter int NUM_PAGES = 128,
    parameter int RST_WAIT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    uc1611_rx_if.slave       bus,
    output logic [7:0]       scroll_line,
    output logic [2:0]       map_ctl,
    output logic [2:0]       addr_ctl,
    output logic [2:0]       disp_en,
    output logic [1:0]       gray_ctl,
    output logic [1:0]       line_rate,
    output logic [1:0]       bias,
    output logic [1:0]       panel_ld,
    output logic [7:0]       gain_pm,
    output logic [1:0]       partial,
    output logic             busy
);

    localparam int         CW       = (RST_WAIT > 0) ? $clog2(RST_WAIT + 1) : 1;
    localparam logic [7:0] COL_MAX  = 8'(NUM_COLS - 1);
    localparam logic [6:0] PAGE_MAX = 7'(NUM_PAGES - 1);

    typedef enum logic [1:0] {CMD, ARG, RSTW} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [7:0]      ca, ca_adv, ca_inc, ca_dec;
    logic [6:0]      pa, pa_adv, pa_inc, pa_dec;
    logic            fb_we_q;
    logic [6:0]      fb_page_q;
    logic [7:0]      fb_col_q;
    logic [7:0]      fb_data_q;
    logic            accept;
    logic            do_cmd, do_data, do_sysrst, load_gain;

    assign accept = bus.lcd_cs & ~bus.lcd_write;
    assign busy   = (state == RSTW);

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_page = fb_page_q;
    assign bus.fb_col  = fb_col_q;
    assign bus.fb_data = fb_data_q;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= CMD;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_cmd     = 1'b0;
        do_data    = 1'b0;
        do_sysrst  = 1'b0;
        load_gain  = 1'b0;
        case (state)
            CMD: begin
                if (accept) begin
                    if (bus.lcd_cd) begin
                        do_data = 1'b1;
                    end else if (bus.lcd_data == 8'h81) begin
                        next_state = ARG;
                    end else if (bus.lcd_data == 8'hE2) begin
                        do_sysrst  = 1'b1;
                        next_state = RSTW;
                    end else begin
                        do_cmd = 1'b1;
                    end
                end
            end
            ARG: begin
                if (accept) begin
                    load_gain  = 1'b1;
                    next_state = CMD;
                end
            end
            RSTW: begin
                if (cnt == '0)
                    next_state = CMD;
            end
            default: next_state = CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (do_sysrst)
            cnt <= CW'(RST_WAIT);
        else if (state == RSTW && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    // Secondary address steps wrap at both ends.
    assign ca_inc = (ca >= COL_MAX)  ? 8'd0 : ca + 8'd1;
    assign ca_dec = (ca == 8'd0)     ? COL_MAX : ca - 8'd1;
    assign pa_inc = (pa >= PAGE_MAX) ? 7'd0 : pa + 7'd1;
    assign pa_dec = (pa == 7'd0)     ? PAGE_MAX : pa - 7'd1;

    always_comb begin
        ca_adv = ca;
        pa_adv = pa;
        if (!addr_ctl[1]) begin
            ca_adv = ca_inc;
            if (ca >= COL_MAX && addr_ctl[0])
                pa_adv = addr_ctl[2] ? pa_dec : pa_inc;
        end else begin
            pa_adv = pa_inc;
            if (pa >= PAGE_MAX && addr_ctl[0])
                ca_adv = addr_ctl[2] ? ca_dec : ca_inc;
        end
    end

    // System Reset command restores exactly the same values as the reset pin.
    always_ff @(posedge clk) begin
        if (!reset || do_sysrst) begin
            ca          <= '0;
            pa          <= '0;
            scroll_line <= '0;
            map_ctl     <= '0;
            addr_ctl    <= 3'b001;
            disp_en     <= '0;
            gray_ctl    <= '0;
            line_rate   <= '0;
            bias        <= 2'b11;
            panel_ld    <= '0;
            gain_pm     <= 8'h00;
            partial     <= '0;
            fb_we_q     <= 1'b0;
            fb_page_q   <= '0;
            fb_col_q    <= '0;
            fb_data_q   <= '0;
        end else begin
            fb_we_q <= 1'b0;
            if (load_gain)
                gain_pm <= bus.lcd_data;
            if (do_data) begin
                fb_we_q   <= 1'b1;
                fb_page_q <= pa;
                fb_col_q  <= ca;
                fb_data_q <= bus.lcd_data;
                ca        <= ca_adv;
                pa        <= pa_adv;
            end
            if (do_cmd) begin
                casez (bus.lcd_data)
                    8'b0000_????: ca[3:0]          <= bus.lcd_data[3:0];
                    8'b0001_????: ca[7:4]          <= bus.lcd_data[3:0];
                    8'b0100_????: scroll_line[3:0] <= bus.lcd_data[3:0];
                    8'b0101_????: scroll_line[7:4] <= bus.lcd_data[3:0];
                    8'b0110_????: pa[3:0]          <= bus.lcd_data[3:0];
                    8'b0111_0???: pa[6:4]          <= bus.lcd_data[2:0];
                    8'b0010_10??: panel_ld         <= bus.lcd_data[1:0];
                    8'b1000_01??: partial          <= bus.lcd_data[1:0];
                    8'b1000_1???: addr_ctl         <= bus.lcd_data[2:0];
                    8'b1010_00??: line_rate        <= bus.lcd_data[1:0];
                    8'b1010_1???: disp_en          <= bus.lcd_data[2:0];
                    8'b1100_0???: map_ctl          <= bus.lcd_data[2:0];
                    8'b1101_00??: gray_ctl         <= bus.lcd_data[1:0];
                    8'b1110_10??: bias             <= bus.lcd_data[1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uc1611_rx.sv
// Directed bench for uc1611_rx: a byte-level behavioural model is checked
// against every output on every cycle, plus hand-computed spot checks.
module tb_uc1611_rx;
    localparam int NC = 160;
    localparam int NP = 128;
    localparam int RW = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scroll_line;
    logic [2:0] map_ctl, addr_ctl, disp_en;
    logic [1:0] gray_ctl, line_rate, bias, panel_ld, partial;
    logic [7:0] gain_pm;
    logic       busy;

    always #5 clk = ~clk;

    uc1611_rx_if bus();

    uc1611_rx #(.NUM_COLS(NC), .NUM_PAGES(NP), .RST_WAIT(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .scroll_line (scroll_line),
        .map_ctl     (map_ctl),
        .addr_ctl    (addr_ctl),
        .disp_en     (disp_en),
        .gray_ctl    (gray_ctl),
        .line_rate   (line_rate),
        .bias        (bias),
        .panel_ld    (panel_ld),
        .gain_pm     (gain_pm),
        .partial     (partial),
        .busy        (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ca, m_pa, m_sl, m_map, m_ac, m_de, m_gray, m_lr, m_bias, m_pld, m_gain, m_part;
    int m_we, m_fp, m_fc, m_fd;
    int m_wait;      // remaining ignore cycles, -1 when not waiting
    bit m_arg;

    task automatic model_reset();
        m_ca = 0; m_pa = 0; m_sl = 0; m_map = 0; m_ac = 1; m_de = 0;
        m_gray = 0; m_lr = 0; m_bias = 3; m_pld = 0; m_gain = 0; m_part = 0;
        m_we = 0; m_fp = 0; m_fc = 0; m_fd = 0;
        m_wait = -1; m_arg = 0;
    endtask

    task automatic model_advance();
        bit page_primary, chain, down;
        page_primary = ((m_ac / 2) % 2) == 1;
        chain        = (m_ac % 2) == 1;
        down         = (m_ac / 4) == 1;
        if (!page_primary) begin
            if (m_ca + 1 >= NC) begin
                m_ca = 0;
                if (chain) m_pa = down ? (m_pa + NP - 1) % NP : (m_pa + 1) % NP;
            end else m_ca = m_ca + 1;
        end else begin
            if (m_pa + 1 >= NP) begin
                m_pa = 0;
                if (chain) m_ca = down ? (m_ca + NC - 1) % NC : (m_ca + 1) % NC;
            end else m_pa = m_pa + 1;
        end
    endtask

    task automatic model_cmd(input int d);
        if (d < 'h10)                       m_ca = m_ca - m_ca % 16 + d % 16;
        else if (d < 'h20)                  m_ca = m_ca % 16 + (d % 16) * 16;
        else if (d >= 'h28 && d <= 'h2B)    m_pld = d % 4;
        else if (d >= 'h40 && d <= 'h4F)    m_sl = m_sl - m_sl % 16 + d % 16;
        else if (d >= 'h50 && d <= 'h5F)    m_sl = m_sl % 16 + (d % 16) * 16;
        else if (d >= 'h60 && d <= 'h6F)    m_pa = m_pa - m_pa % 16 + d % 16;
        else if (d >= 'h70 && d <= 'h77)    m_pa = m_pa % 16 + (d % 8) * 16;
        else if (d == 'h81)                 m_arg = 1;
        else if (d >= 'h84 && d <= 'h87)    m_part = d % 4;
        else if (d >= 'h88 && d <= 'h8F)    m_ac = d % 8;
        else if (d >= 'hA0 && d <= 'hA3)    m_lr = d % 4;
        else if (d >= 'hA8 && d <= 'hAF)    m_de = d % 8;
        else if (d >= 'hC0 && d <= 'hC7)    m_map = d % 8;
        else if (d >= 'hD0 && d <= 'hD3)    m_gray = d % 4;
        else if (d == 'hE2) begin
            model_reset();
            m_wait = RW;
        end
        else if (d >= 'hE8 && d <= 'hEB)    m_bias = d % 4;
    endtask

    task automatic model_step();
        int d;
        d = int'(bus.lcd_data);
        m_we = 0;
        if (!reset) begin
            model_reset();
        end else if (m_wait >= 0) begin
            m_wait = (m_wait == 0) ? -1 : m_wait - 1;
        end else if (bus.lcd_cs && !bus.lcd_write) begin
            if (m_arg) begin
                m_gain = d;
                m_arg  = 0;
            end else if (bus.lcd_cd) begin
                m_we = 1; m_fp = m_pa; m_fc = m_ca; m_fd = d;
                model_advance();
            end else begin
                model_cmd(d);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    int log_p[$], log_c[$], log_d[$];

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("fb_we",       bus.fb_we,   m_we);
            chk("fb_page",     bus.fb_page, m_fp);
            chk("fb_col",      bus.fb_col,  m_fc);
            chk("fb_data",     bus.fb_data, m_fd);
            chk("scroll_line", scroll_line, m_sl);
            chk("map_ctl",     map_ctl,     m_map);
            chk("addr_ctl",    addr_ctl,    m_ac);
            chk("disp_en",     disp_en,     m_de);
            chk("gray_ctl",    gray_ctl,    m_gray);
            chk("line_rate",   line_rate,   m_lr);
            chk("bias",        bias,        m_bias);
            chk("panel_ld",    panel_ld,    m_pld);
            chk("gain_pm",     gain_pm,     m_gain);
            chk("partial",     partial,     m_part);
            chk("busy",        busy,        (m_wait >= 0) ? 1 : 0);
            if (bus.fb_we === 1'b1) begin
                log_p.push_back(int'(bus.fb_page));
                log_c.push_back(int'(bus.fb_col));
                log_d.push_back(int'(bus.fb_data));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic cd, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_cs = 1'b1; bus.lcd_write = 1'b0; bus.lcd_cd = cd; bus.lcd_data = d;
    endtask

    task automatic cmd(input logic [7:0] d);
        send(1'b0, d);
    endtask

    task automatic dat(input logic [7:0] d);
        send(1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.lcd_cs = 1'b0; bus.lcd_write = 1'b1;
        end
    endtask

    task automatic clear_log();
        log_p.delete(); log_c.delete(); log_d.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sweep [12];
        int n;
        sweep = '{8'h2A, 8'h86, 8'hA2, 8'hAD, 8'hC5, 8'hD2, 8'hE9,
                  8'h4C, 8'h5A, 8'h78, 8'h30, 8'hFF};

        // byte presented during reset must be ignored
        bus.lcd_cs = 1'b1; bus.lcd_write = 1'b0; bus.lcd_cd = 1'b0; bus.lcd_data = 8'h4F;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; bus.lcd_cs = 1'b0; bus.lcd_write = 1'b1;
        idle(1);
        chk("rst_scroll", scroll_line, 0);
        chk("rst_addr_ctl", addr_ctl, 1);
        chk("rst_bias", bias, 3);
        chk("rst_busy", busy, 0);

        // command decode sweep, including undecoded bytes
        foreach (sweep[i]) cmd(sweep[i]);
        idle(2);
        chk("sweep_scroll", scroll_line, 8'hAC);
        chk("sweep_disp_en", disp_en, 5);
        chk("sweep_bias", bias, 1);

        // not-accepted bytes
        @(negedge clk);
        bus.lcd_cs = 1'b0; bus.lcd_write = 1'b0; bus.lcd_cd = 1'b0; bus.lcd_data = 8'h47;
        @(negedge clk);
        bus.lcd_cs = 1'b1; bus.lcd_write = 1'b1; bus.lcd_data = 8'h48;
        idle(2);
        chk("noaccept_scroll", scroll_line, 8'hAC);

        // page-primary sweep with column step
        clear_log();
        cmd(8'h8B); cmd(8'h60); cmd(8'h70); cmd(8'h00); cmd(8'h10);
        repeat (129) dat(8'hAA);
        idle(3);
        chk("pp_count", log_p.size(), 129);
        if (log_p.size() == 129) begin
            chk("pp_first_page", log_p[0], 0);
            chk("pp_first_col", log_c[0], 0);
            chk("pp_127_page", log_p[127], 127);
            chk("pp_127_col", log_c[127], 0);
            chk("pp_128_page", log_p[128], 0);
            chk("pp_128_col", log_c[128], 1);
            chk("pp_128_data", log_d[128], 8'hAA);
        end

        // column-primary wrap stepping the page
        clear_log();
        cmd(8'h89); cmd(8'h0F); cmd(8'h19); cmd(8'h65); cmd(8'h70);
        dat(8'h12); dat(8'h34);
        idle(3);
        chk("cp_count", log_p.size(), 2);
        if (log_p.size() == 2) begin
            chk("cp_w0_page", log_p[0], 5);
            chk("cp_w0_col", log_c[0], 159);
            chk("cp_w0_data", log_d[0], 8'h12);
            chk("cp_w1_page", log_p[1], 6);
            chk("cp_w1_col", log_c[1], 0);
            chk("cp_w1_data", log_d[1], 8'h34);
        end

        // page primary, column steps down; then column primary without step
        clear_log();
        cmd(8'h8F); cmd(8'h6F); cmd(8'h77); cmd(8'h00); cmd(8'h10);
        dat(8'h01); dat(8'h02);
        cmd(8'h8C); cmd(8'h0F); cmd(8'h19);
        dat(8'h03); dat(8'h04);
        idle(3);
        chk("dn_count", log_p.size(), 4);
        if (log_p.size() == 4) begin
            chk("dn_w0_page", log_p[0], 127);
            chk("dn_w0_col", log_c[0], 0);
            chk("dn_w1_page", log_p[1], 0);
            chk("dn_w1_col", log_c[1], 159);
            chk("ns_w2_page", log_p[2], 1);
            chk("ns_w2_col", log_c[2], 159);
            chk("ns_w3_page", log_p[3], 1);
            chk("ns_w3_col", log_c[3], 0);
        end

        // gain argument delivered with lcd_cd=1
        clear_log();
        cmd(8'h81); dat(8'h46);
        idle(2);
        chk("arg_gain", gain_pm, 8'h46);
        chk("arg_no_write", log_p.size(), 0);

        // system reset command and busy window
        clear_log();
        cmd(8'hAF);
        idle(1);
        chk("de_set", disp_en, 7);
        cmd(8'hE2); dat(8'h55);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            bus.lcd_cs = 1'b0; bus.lcd_write = 1'b1;
        end
        idle(2);
        chk("sr_busy_cycles", n, RW + 1);
        chk("sr_disp_en", disp_en, 0);
        chk("sr_gain", gain_pm, 0);
        chk("sr_addr_ctl", addr_ctl, 1);
        chk("sr_no_write", log_p.size(), 0);

        // reset pin aborts ARG
        clear_log();
        cmd(8'h81);
        @(negedge clk);
        reset = 1'b0; bus.lcd_cs = 1'b0; bus.lcd_write = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        cmd(8'h46); dat(8'h77);
        idle(3);
        chk("ra_scroll", scroll_line, 6);
        chk("ra_gain", gain_pm, 0);
        chk("ra_count", log_p.size(), 1);
        if (log_p.size() == 1) begin
            chk("ra_page", log_p[0], 0);
            chk("ra_col", log_c[0], 0);
            chk("ra_data", log_d[0], 8'h77);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
